// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for serial_subtractor: request and operands toward the
// block, status and difference back from it.
interface serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;

   modport master (
      output start, a, b,
      input  busy, done, diff, bout
   );

   modport slave (
      input  start, a, b,
      output busy, done, diff, bout
   );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell plus a borrow flop,
// LSB first, producing (a - b) mod 2^WIDTH and the final borrow.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   serial_subtractor_if.slave   s_if
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Returns {borrow_out, difference_bit}
   function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bin);
      full_sub = {(~x & y) | (~(x ^ y) & bin), x ^ y ^ bin};
   endfunction

   state_t           r_state;
   state_t           w_next_state;
   logic [WIDTH-1:0] r_sa;
   logic [WIDTH-1:0] r_sb;
   logic [WIDTH-1:0] r_diff;
   logic [CW-1:0]    r_cnt;
   logic             r_borrow;
   logic             r_bout;
   logic             r_busy;
   logic             r_done;
   logic [1:0]       w_fs;
   logic             w_last;

   // Next-state decode and the single full-subtractor cell
   always_comb begin
      w_next_state = r_state;
      w_fs         = full_sub(r_sa[0], r_sb[0], r_borrow);
      w_last       = (r_cnt == CW'(WIDTH - 1));
      case (r_state)
         ST_IDLE: begin
            if (s_if.start) w_next_state = ST_RUN;
            else            w_next_state = ST_IDLE;
         end
         ST_RUN: begin
            if (w_last) w_next_state = ST_DONE;
            else        w_next_state = ST_RUN;
         end
         ST_DONE: w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   // State register with busy/done registered from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_busy  <= (w_next_state != ST_IDLE);
         r_done  <= (w_next_state == ST_DONE);
      end
   end

   // Operand shifters, borrow flop, counter and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sa     <= '0;
         r_sb     <= '0;
         r_diff   <= '0;
         r_cnt    <= '0;
         r_borrow <= 1'b0;
         r_bout   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (s_if.start) begin
                  r_sa     <= s_if.a;
                  r_sb     <= s_if.b;
                  r_borrow <= 1'b0;
                  r_cnt    <= '0;
               end
            end
            ST_RUN: begin
               r_diff   <= {w_fs[0], r_diff[WIDTH-1:1]};
               r_sa     <= {1'b0, r_sa[WIDTH-1:1]};
               r_sb     <= {1'b0, r_sb[WIDTH-1:1]};
               r_borrow <= w_fs[1];
               r_cnt    <= r_cnt + CW'(1);
               if (w_last) r_bout <= w_fs[1];
            end
            default: begin
               r_cnt <= r_cnt;
            end
         endcase
      end
   end

   assign s_if.busy = r_busy;
   assign s_if.done = r_done;
   assign s_if.diff = r_diff;
   assign s_if.bout = r_bout;
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=4 instances)
// against plain modular-arithmetic expectations.
module tb_serial_subtractor;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   logic [7:0] prev_diff = 8'd0;
   logic       prev_bout = 1'b0;

   always #5 clk = ~clk;

   serial_subtractor_if #(.WIDTH(8)) bus8 ();
   serial_subtractor_if #(.WIDTH(4)) bus4 ();

   serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .s_if(bus8.slave));
   serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .s_if(bus4.slave));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_done8(output int n);
      n = 0;
      while (bus8.done !== 1'b1 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   // Reference: unsigned subtraction modulo 256, borrow iff a < b
   task automatic do_op(input logic [7:0] a, input logic [7:0] b);
      int n;
      logic [7:0] ed;
      logic       eb;
      ed = 8'((int'(a) - int'(b) + 256) % 256);
      eb = (a < b);
      bus8.a = a; bus8.b = b; bus8.start = 1'b1;
      @(posedge clk); #1;
      bus8.start = 1'b0;
      check("busy_rise", bus8.busy, 1);
      check("diff_hold", bus8.diff, prev_diff);
      check("bout_hold", bus8.bout, prev_bout);
      wait_done8(n);
      check("latency", n, 8);
      check("diff", bus8.diff, ed);
      check("bout", bus8.bout, eb);
      check("busy_in_done", bus8.busy, 1);
      prev_diff = ed; prev_bout = eb;
      @(posedge clk); #1;
      check("done_pulse", bus8.done, 0);
      check("busy_fall", bus8.busy, 0);
      check("diff_stable", bus8.diff, ed);
   endtask

   initial begin
      int n;
      int dones;
      logic [7:0] ra, rb;
      bus8.start = 1'b0; bus8.a = 8'd0; bus8.b = 8'd0;
      bus4.start = 1'b0; bus4.a = 4'd0; bus4.b = 4'd0;
      #1;
      check("rst_busy", bus8.busy, 0);
      check("rst_done", bus8.done, 0);
      check("rst_diff", bus8.diff, 0);
      check("rst_bout", bus8.bout, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      do_op(8'd5, 8'd3);
      do_op(8'd3, 8'd5);
      do_op(8'd0, 8'd1);
      do_op(8'd0, 8'd0);
      do_op(8'd255, 8'd255);
      do_op(8'd255, 8'd0);
      do_op(8'd0, 8'd255);

      // Start pulsed mid-RUN with other operands is ignored
      bus8.a = 8'd100; bus8.b = 8'd37; bus8.start = 1'b1;
      @(posedge clk); #1;
      bus8.start = 1'b0;
      for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
      bus8.a = 8'd7; bus8.b = 8'd200; bus8.start = 1'b1;
      @(posedge clk); #1;
      bus8.start = 1'b0;
      wait_done8(n);
      check("midrun_latency", n, 4);
      check("midrun_diff", bus8.diff, 63);
      check("midrun_bout", bus8.bout, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("midrun_no_queue", bus8.busy, 0);
      prev_diff = 8'd63; prev_bout = 1'b0;

      // Start held high: back-to-back results every WIDTH+2 cycles
      bus8.a = 8'd10; bus8.b = 8'd20; bus8.start = 1'b1;
      @(posedge clk); #1;
      wait_done8(n);
      check("b2b_first_lat", n, 8);
      check("b2b_first_diff", bus8.diff, 246);
      check("b2b_first_bout", bus8.bout, 1);
      bus8.a = 8'd200; bus8.b = 8'd55;
      wait_done8(n);
      if (n == 0) begin @(posedge clk); #1; wait_done8(n); n++; end
      check("b2b_period", n, 10);
      check("b2b_second_diff", bus8.diff, 145);
      check("b2b_second_bout", bus8.bout, 0);
      bus8.start = 1'b0;
      prev_diff = 8'd145; prev_bout = 1'b0;
      @(posedge clk); #1;
      check("b2b_idle", bus8.busy, 0);
      @(posedge clk); #1;

      // Asynchronous reset between edges aborts a running operation
      bus8.a = 8'd77; bus8.b = 8'd99; bus8.start = 1'b1;
      @(posedge clk); #1;
      bus8.start = 1'b0;
      for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_busy", bus8.busy, 0);
      check("arst_done", bus8.done, 0);
      check("arst_diff", bus8.diff, 0);
      check("arst_bout", bus8.bout, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (bus8.done === 1'b1) dones++;
      end
      check("arst_no_done", dones, 0);
      check("arst_idle", bus8.busy, 0);
      prev_diff = 8'd0; prev_bout = 1'b0;
      do_op(8'd77, 8'd99);

      for (int i = 0; i < 200; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         do_op(ra, rb);
      end

      // WIDTH=4 instance
      bus4.a = 4'd2; bus4.b = 4'd7; bus4.start = 1'b1;
      @(posedge clk); #1;
      bus4.start = 1'b0;
      check("w4_busy", bus4.busy, 1);
      n = 0;
      while (bus4.done !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("w4_latency", n, 4);
      check("w4_diff", bus4.diff, 11);
      check("w4_bout", bus4.bout, 1);
      @(posedge clk); #1;
      check("w4_busy_fall", bus4.busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
